// File: rtl/iir_deemph_if.sv
// Handshake bundle between the de-emphasis filter and its upstream/downstream FIFOs.
// The master side is the FIFO/bench side; the slave side is the filter.
interface iir_deemph_if #(
    parameter int DATA_WIDTH = 32
);
    logic                         in_empty;
    logic signed [DATA_WIDTH-1:0] in_dout;
    logic                         in_rd_en;
    logic                         out_full;
    logic                         out_wr_en;
    logic signed [DATA_WIDTH-1:0] out_din;

    modport master (
        output in_empty, in_dout, out_full,
        input  in_rd_en, out_wr_en, out_din
    );

    modport slave (
        input  in_empty, in_dout, out_full,
        output in_rd_en, out_wr_en, out_din
    );
endinterface

// File: rtl/iir_deemph.sv
// First-order Q10 IIR de-emphasis filter between two FIFOs.
// Each sample takes four cycles: read, multiply, sum, write (write may stall).
module iir_deemph #(
    parameter int                          DATA_WIDTH = 32,
    parameter logic signed [DATA_WIDTH-1:0] B0        = 32'sd178,
    parameter logic signed [DATA_WIDTH-1:0] B1        = 32'sd178,
    parameter logic signed [DATA_WIDTH-1:0] A1        = -32'sd666
) (
    input  logic           clock,
    input  logic           reset,
    iir_deemph_if.slave    bus
);
    localparam int PW        = 2 * DATA_WIDTH;
    localparam int DEQ_SHIFT = 10;
    // Adding 2^10-1 before the arithmetic shift turns floor into truncation toward zero for negatives.
    localparam logic signed [PW-1:0] DEQ_BIAS = {{(PW-10){1'b0}}, 10'd1023};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MULT  = 2'd1,
        S_SUM   = 2'd2,
        S_WRITE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic signed [DATA_WIDTH-1:0] x0_q, x0_d;
    logic signed [DATA_WIDTH-1:0] x1_q, x1_d;
    logic signed [DATA_WIDTH-1:0] y1_q, y1_d;
    logic signed [DATA_WIDTH-1:0] y_out_q, y_out_d;
    logic signed [DATA_WIDTH-1:0] p0_q, p0_d;
    logic signed [DATA_WIDTH-1:0] p1_q, p1_d;
    logic signed [DATA_WIDTH-1:0] p2_q, p2_d;
    logic signed [DATA_WIDTH-1:0] sum_s;
    logic                         in_rd_en_s;
    logic                         out_wr_en_s;

    function automatic logic signed [PW-1:0] mul_full(
        input logic signed [DATA_WIDTH-1:0] c,
        input logic signed [DATA_WIDTH-1:0] x
    );
        logic signed [PW-1:0] cw;
        logic signed [PW-1:0] xw;
        cw = {{DATA_WIDTH{c[DATA_WIDTH-1]}}, c};
        xw = {{DATA_WIDTH{x[DATA_WIDTH-1]}}, x};
        return cw * xw;
    endfunction

    function automatic logic signed [DATA_WIDTH-1:0] deq(input logic signed [PW-1:0] p);
        logic signed [PW-1:0] adj;
        logic signed [PW-1:0] q;
        if (p[PW-1]) begin
            adj = p + DEQ_BIAS;
        end else begin
            adj = p;
        end
        q = adj >>> DEQ_SHIFT;
        return q[DATA_WIDTH-1:0];
    endfunction

    assign sum_s         = p0_q + p1_q + p2_q;
    assign bus.in_rd_en  = in_rd_en_s;
    assign bus.out_wr_en = out_wr_en_s;
    assign bus.out_din   = y_out_q;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_rd_en_s) state_d = S_MULT; else state_d = S_IDLE;
            S_MULT:  state_d = S_SUM;
            S_SUM:   state_d = S_WRITE;
            S_WRITE: if (out_wr_en_s) state_d = S_IDLE; else state_d = S_WRITE;
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO strobes: combinational from state and flags, held low while in reset
    always_comb begin
        in_rd_en_s  = 1'b0;
        out_wr_en_s = 1'b0;
        case (state_q)
            S_IDLE:  in_rd_en_s  = reset & ~bus.in_empty;
            S_WRITE: out_wr_en_s = reset & ~bus.out_full;
            default: begin
                in_rd_en_s  = 1'b0;
                out_wr_en_s = 1'b0;
            end
        endcase
    end

    // Datapath next values; every register holds unless its stage is active
    always_comb begin
        x0_d    = x0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        y_out_d = y_out_q;
        p0_d    = p0_q;
        p1_d    = p1_q;
        p2_d    = p2_q;
        case (state_q)
            S_IDLE: begin
                if (in_rd_en_s) begin
                    x0_d = bus.in_dout;
                end else begin
                    x0_d = x0_q;
                end
            end
            S_MULT: begin
                p0_d = deq(mul_full(B0, x0_q));
                p1_d = deq(mul_full(B1, x1_q));
                p2_d = deq(mul_full(A1, y1_q));
            end
            S_SUM: begin
                y_out_d = sum_s;
                x1_d    = x0_q;
                y1_d    = sum_s;
            end
            default: begin
                y_out_d = y_out_q;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            x0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            y_out_q <= '0;
            p0_q    <= '0;
            p1_q    <= '0;
            p2_q    <= '0;
        end else begin
            x0_q    <= x0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            y_out_q <= y_out_d;
            p0_q    <= p0_d;
            p1_q    <= p1_d;
            p2_q    <= p2_d;
        end
    end
endmodule

// File: tb/tb_iir_deemph.sv
// Directed bench for iir_deemph: impulse, step, truncation, underflow,
// backpressure and mid-sample reset, with hand-computed expected outputs.
module tb_iir_deemph;
    localparam int W = 32;

    logic clock;
    logic reset;
    int   n_cmp;
    int   n_bad;
    int   wr_count;

    iir_deemph_if #(.DATA_WIDTH(W)) bus ();

    iir_deemph #(.DATA_WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count every write the downstream FIFO would accept
    always @(posedge clock) begin
        if (bus.out_wr_en) wr_count <= wr_count + 1;
    end

    task automatic check_val(input string tag, input longint obs, input longint exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset        = 1'b0;
        bus.in_empty = 1'b0;
        bus.out_full = 1'b0;
        #1;
        check_val("rst_rd", bus.in_rd_en, 0);
        check_val("rst_wr", bus.out_wr_en, 0);
        check_val("rst_dout", bus.out_din, 0);
        @(negedge clock);
        @(negedge clock);
        reset        = 1'b1;
        bus.in_empty = 1'b1;
    endtask

    // Feed one sample, keep in_empty low while it is pending, optionally stall the write
    task automatic run_sample(input string tag, input logic signed [W-1:0] x,
                              input logic signed [W-1:0] exp_y, input int stall);
        @(negedge clock);
        bus.in_empty = 1'b0;
        bus.in_dout  = x;
        bus.out_full = (stall > 0);
        #1;
        check_val({tag, "_rd"}, bus.in_rd_en, 1);
        for (int c = 1; c < 3; c++) begin
            @(negedge clock);
            #1;
            check_val({tag, "_busy"}, bus.in_rd_en | bus.out_wr_en, 0);
        end
        @(negedge clock);
        #1;
        for (int s = 0; s < stall; s++) begin
            check_val({tag, "_stall_wr"}, bus.out_wr_en, 0);
            check_val({tag, "_stall_rd"}, bus.in_rd_en, 0);
            check_val({tag, "_stall_hold"}, bus.out_din, exp_y);
            @(negedge clock);
            #1;
        end
        bus.out_full = 1'b0;
        #1;
        check_val({tag, "_wr"}, bus.out_wr_en, 1);
        check_val({tag, "_dout"}, bus.out_din, exp_y);
        @(posedge clock);
        #1;
        bus.in_empty = 1'b1;
    endtask

    initial begin
        n_cmp        = 0;
        n_bad        = 0;
        wr_count     = 0;
        reset        = 1'b0;
        bus.in_empty = 1'b0;
        bus.in_dout  = '0;
        bus.out_full = 1'b0;
        @(negedge clock);
        #1;
        check_val("init_rd", bus.in_rd_en, 0);
        check_val("init_wr", bus.out_wr_en, 0);
        check_val("init_dout", bus.out_din, 0);
        @(negedge clock);
        reset        = 1'b1;
        bus.in_empty = 1'b1;

        run_sample("imp0", 1024, 178, 0);
        run_sample("imp1", 0, 63, 0);
        run_sample("imp2", 0, -40, 0);

        do_reset();
        run_sample("stp0", 1024, 178, 0);
        run_sample("stp1", 1024, 241, 0);
        run_sample("stp2", 1024, 200, 0);
        run_sample("stp3", 1024, 226, 0);

        do_reset();
        run_sample("trn0", -1, 0, 0);
        run_sample("trn1", 0, 0, 0);

        bus.in_empty = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            #1;
            check_val("undf_rd", bus.in_rd_en, 0);
            check_val("undf_wr", bus.out_wr_en, 0);
        end

        run_sample("bp", 1024, 178, 5);
        check_val("wr_count_a", wr_count, 10);

        // Start a sample that would give 241, then reset while it is in the sum stage
        @(negedge clock);
        bus.in_empty = 1'b0;
        bus.in_dout  = 1024;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_val("mid_rd", bus.in_rd_en, 0);
        check_val("mid_wr", bus.out_wr_en, 0);
        check_val("mid_dout", bus.out_din, 0);
        for (int i = 0; i < 3; i++) @(negedge clock);
        check_val("mid_nowrite", wr_count, 10);
        reset        = 1'b1;
        bus.in_empty = 1'b1;
        run_sample("post", 1024, 178, 0);
        check_val("wr_count_b", wr_count, 11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
